// File: rtl/coherent_sum.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : coherent_sum
// Description : Drains the coherent FIFO and accumulates per-correlator I/Q
//               words over a programmable number of epochs, one sum each.
// Revision    : 1.0 - initial release
// ============================================================================
module coherent_sum #(
    parameter int DATA_WIDTH = 44,
    parameter int SUM_WIDTH  = 32,
    parameter int CORR_NUM   = 8
) (
    input  logic                        clk,
    input  logic                        rst_b,
    input  logic                        enable,
    input  logic [5:0]                  coh_number,
    input  logic                        fifo_empty,
    output logic                        fifo_rd,
    input  logic [DATA_WIDTH-1:0]       fifo_data,
    output logic                        sum_valid,
    output logic [$clog2(CORR_NUM)-1:0] sum_index,
    output logic [SUM_WIDTH-1:0]        sum_i,
    output logic [SUM_WIDTH-1:0]        sum_q,
    output logic                        coh_done,
    output logic                        busy
);

    localparam int c_half_w = DATA_WIDTH / 2;
    localparam int c_idx_w  = $clog2(CORR_NUM);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(CORR_NUM - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [5:0]                  coh_len_q, coh_len_d;
    logic [5:0]                  epoch_q, epoch_d;
    logic [c_idx_w-1:0]          corr_q, corr_d;
    logic                        rd_d1_q;
    logic                        sum_valid_q, sum_valid_d;
    logic                        coh_done_q, coh_done_d;
    logic [c_idx_w-1:0]          sum_index_q, sum_index_d;
    logic signed [SUM_WIDTH-1:0] sum_i_q, sum_i_d;
    logic signed [SUM_WIDTH-1:0] sum_q_q, sum_q_d;
    logic signed [SUM_WIDTH-1:0] acc_i_q [CORR_NUM];
    logic signed [SUM_WIDTH-1:0] acc_q_q [CORR_NUM];

    logic signed [c_half_w-1:0]  w_raw_i, w_raw_q;
    logic signed [SUM_WIDTH-1:0] w_data_i, w_data_q;
    logic signed [SUM_WIDTH-1:0] w_res_i, w_res_q;
    logic                        w_last_epoch;

    // Two's-complement add with clamp to the representable range on overflow.
    function automatic logic signed [SUM_WIDTH-1:0] sat_add(
        input logic signed [SUM_WIDTH-1:0] a,
        input logic signed [SUM_WIDTH-1:0] b
    );
        logic [SUM_WIDTH:0] s;
        s = {a[SUM_WIDTH-1], a} + {b[SUM_WIDTH-1], b};
        if (s[SUM_WIDTH] != s[SUM_WIDTH-1]) begin
            sat_add = s[SUM_WIDTH] ? {1'b1, {(SUM_WIDTH-1){1'b0}}}
                                   : {1'b0, {(SUM_WIDTH-1){1'b1}}};
        end else begin
            sat_add = s[SUM_WIDTH-1:0];
        end
    endfunction

    assign w_raw_i      = fifo_data[DATA_WIDTH-1:c_half_w];
    assign w_raw_q      = fifo_data[c_half_w-1:0];
    assign w_data_i     = SUM_WIDTH'(w_raw_i);
    assign w_data_q     = SUM_WIDTH'(w_raw_q);
    assign w_last_epoch = (epoch_q == (coh_len_q - 6'd1));

    // Epoch 0 reloads the accumulator, so stale content never leaks forward.
    assign w_res_i = (epoch_q == 6'd0) ? w_data_i : sat_add(acc_i_q[corr_q], w_data_i);
    assign w_res_q = (epoch_q == 6'd0) ? w_data_q : sat_add(acc_q_q[corr_q], w_data_q);

    assign fifo_rd   = rst_b && (state_q == ST_RUN) && enable && !fifo_empty;
    assign busy      = (state_q != ST_IDLE);
    assign sum_valid = sum_valid_q;
    assign coh_done  = coh_done_q;
    assign sum_index = sum_index_q;
    assign sum_i     = sum_i_q;
    assign sum_q     = sum_q_q;

    always_comb begin
        state_d     = state_q;
        coh_len_d   = coh_len_q;
        epoch_d     = epoch_q;
        corr_d      = corr_q;
        sum_valid_d = 1'b0;
        coh_done_d  = 1'b0;
        sum_index_d = sum_index_q;
        sum_i_d     = sum_i_q;
        sum_q_d     = sum_q_q;

        case (state_q)
            ST_IDLE: begin
                corr_d  = '0;
                epoch_d = '0;
                if (enable) begin
                    state_d   = ST_RUN;
                    coh_len_d = (coh_number == 6'd0) ? 6'd1 : coh_number;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (rd_d1_q) begin
            corr_d = corr_q + 1'b1;
            if (corr_q == c_last_idx) begin
                epoch_d = w_last_epoch ? 6'd0 : (epoch_q + 6'd1);
            end
            if (w_last_epoch) begin
                sum_valid_d = 1'b1;
                coh_done_d  = (corr_q == c_last_idx);
                sum_index_d = corr_q;
                sum_i_d     = w_res_i;
                sum_q_d     = w_res_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q     <= ST_IDLE;
            coh_len_q   <= 6'd1;
            epoch_q     <= '0;
            corr_q      <= '0;
            rd_d1_q     <= 1'b0;
            sum_valid_q <= 1'b0;
            coh_done_q  <= 1'b0;
            sum_index_q <= '0;
            sum_i_q     <= '0;
            sum_q_q     <= '0;
            for (int k = 0; k < CORR_NUM; k++) begin
                acc_i_q[k] <= '0;
                acc_q_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            coh_len_q   <= coh_len_d;
            epoch_q     <= epoch_d;
            corr_q      <= corr_d;
            rd_d1_q     <= fifo_rd;
            sum_valid_q <= sum_valid_d;
            coh_done_q  <= coh_done_d;
            sum_index_q <= sum_index_d;
            sum_i_q     <= sum_i_d;
            sum_q_q     <= sum_q_d;
            if (rd_d1_q) begin
                acc_i_q[corr_q] <= w_res_i;
                acc_q_q[corr_q] <= w_res_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_coherent_sum.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_coherent_sum
// Description : Randomised scoreboard bench for coherent_sum with a FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coherent_sum;

    localparam int DW = 44;
    localparam int SW = 24;
    localparam int CN = 8;
    localparam int HW = DW / 2;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          enable;
    logic [5:0]    coh_number;
    logic          fifo_empty;
    logic          fifo_rd;
    logic [DW-1:0] fifo_data;
    logic          sum_valid;
    logic [2:0]    sum_index;
    logic [SW-1:0] sum_i;
    logic [SW-1:0] sum_q;
    logic          coh_done;
    logic          busy;

    coherent_sum #(.DATA_WIDTH(DW), .SUM_WIDTH(SW), .CORR_NUM(CN)) dut (
        .clk(clk), .rst_b(rst_b), .enable(enable), .coh_number(coh_number),
        .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .fifo_data(fifo_data),
        .sum_valid(sum_valid), .sum_index(sum_index), .sum_i(sum_i), .sum_q(sum_q),
        .coh_done(coh_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     idx;
        longint si;
        longint sq;
        bit     done;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] fifo_q[$];
    longint        wl_i[$];
    longint        wl_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rd_count = 0;
    int rd_bad = 0;
    int first_rd = -1;
    int first_sv = -1;
    bit toggle_mode = 1'b0;
    bit gate = 1'b0;
    bit pend = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic longint clampv(input longint v);
        longint mx;
        longint mn;
        mx = (longint'(1) << (SW - 1)) - 1;
        mn = -(longint'(1) << (SW - 1));
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

    function automatic longint rnd_half();
        return longint'($urandom_range(0, (1 << HW) - 1)) - (longint'(1) << (HW - 1));
    endfunction

    task automatic add_word(input longint vi, input longint vq);
        logic [HW-1:0] a;
        logic [HW-1:0] b;
        a = vi[HW-1:0];
        b = vq[HW-1:0];
        fifo_q.push_back({a, b});
        wl_i.push_back(vi);
        wl_q.push_back(vq);
    endtask

    // Expected sums for every complete coherent period of the queued words.
    task automatic build_expect(input int cohn);
        int L;
        exp_t e;
        longint ai;
        longint aq;
        L = (cohn == 0) ? 1 : cohn;
        for (int base = 0; base + L * CN <= wl_i.size(); base += L * CN) begin
            for (int c = 0; c < CN; c++) begin
                ai = 0;
                aq = 0;
                for (int ep = 0; ep < L; ep++) begin
                    if (ep == 0) begin
                        ai = wl_i[base + c];
                        aq = wl_q[base + c];
                    end else begin
                        ai = clampv(ai + wl_i[base + ep * CN + c]);
                        aq = clampv(aq + wl_q[base + ep * CN + c]);
                    end
                end
                e.idx  = c;
                e.si   = ai;
                e.sq   = aq;
                e.done = (c == CN - 1);
                exp_q.push_back(e);
            end
        end
        wl_i.delete();
        wl_q.delete();
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 20; n++) begin
            @(posedge clk);
            #2;
            if (!busy) break;
        end
        chk("busy_clears", longint'(busy), 0);
    endtask

    task automatic run_batch(input int cohn, input bit tog);
        int n;
        coh_number  = 6'(cohn);
        toggle_mode = tog;
        @(posedge clk);
        #1 enable = 1'b1;
        for (n = 0; n < 20000; n++) begin
            @(posedge clk);
            #2;
            if (fifo_q.size() == 0 && exp_q.size() == 0) break;
        end
        chk("batch_drained_outstanding", longint'(exp_q.size()), 0);
        enable = 1'b0;
        toggle_mode = 1'b0;
        wait_idle();
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_sum_valid"}, longint'(sum_valid), 0);
        chk({tag, "_sum_i"},     longint'(sum_i), 0);
        chk({tag, "_sum_q"},     longint'(sum_q), 0);
        chk({tag, "_sum_index"}, longint'(sum_index), 0);
        chk({tag, "_coh_done"},  longint'(coh_done), 0);
        chk({tag, "_busy"},      longint'(busy), 0);
        chk({tag, "_fifo_rd"},   longint'(fifo_rd), 0);
    endtask

    // FIFO model: data appears the cycle after a sampled read request.
    initial begin
        fifo_empty = 1'b1;
        fifo_data  = '0;
        forever begin
            @(negedge clk);
            pend = fifo_rd;
            if (fifo_rd) begin
                rd_count++;
                if (first_rd < 0) first_rd = cyc;
                if (fifo_empty) rd_bad++;
            end
            @(posedge clk);
            #1;
            if (pend && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
            gate = ~gate;
            fifo_empty = (fifo_q.size() == 0) || (toggle_mode && gate);
        end
    end

    // Monitor: pops the scoreboard on every sum pulse, checks hold otherwise.
    initial begin
        exp_t e;
        logic [SW-1:0] last_i;
        logic [SW-1:0] last_q;
        logic [2:0]    last_idx;
        last_i = '0;
        last_q = '0;
        last_idx = '0;
        forever begin
            @(negedge clk);
            if (!rst_b) begin
                last_i = '0;
                last_q = '0;
                last_idx = '0;
            end else if (sum_valid) begin
                if (first_sv < 0) first_sv = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_sum: actual idx=%0d i=%0d q=%0d, required no pulse",
                             sum_index, $signed(sum_i), $signed(sum_q));
                end else begin
                    e = exp_q.pop_front();
                    if (int'(sum_index) != e.idx || longint'($signed(sum_i)) != e.si ||
                        longint'($signed(sum_q)) != e.sq || coh_done != e.done) begin
                        failures++;
                        $display("FAIL sum: actual idx=%0d i=%0d q=%0d done=%0d required idx=%0d i=%0d q=%0d done=%0d",
                                 sum_index, $signed(sum_i), $signed(sum_q), coh_done,
                                 e.idx, e.si, e.sq, e.done);
                    end
                end
                last_i = sum_i;
                last_q = sum_q;
                last_idx = sum_index;
            end else begin
                checks++;
                if (coh_done !== 1'b0 || sum_i !== last_i || sum_q !== last_q ||
                    sum_index !== last_idx) begin
                    failures++;
                    $display("FAIL hold: actual i=%0d q=%0d idx=%0d done=%0d required i=%0d q=%0d idx=%0d done=0",
                             $signed(sum_i), $signed(sum_q), sum_index, coh_done,
                             $signed(last_i), $signed(last_q), last_idx);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int cohn;
        int nper;
        rst_b = 1'b0;
        enable = 1'b0;
        coh_number = 6'd1;
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b1;
        @(negedge clk);
        check_zero_outputs("reset");

        // Ramp, one epoch per sum, plus first-pulse latency
        first_rd = -1;
        first_sv = -1;
        for (int k = 0; k < CN; k++) add_word(k, -k);
        build_expect(1);
        run_batch(1, 1'b0);
        chk("first_pulse_latency", first_sv - first_rd, 2);

        // Constant words over four epochs, then again with a gapped FIFO
        for (int k = 0; k < 4 * CN; k++) add_word(1000, -3);
        build_expect(4);
        run_batch(4, 1'b0);
        for (int k = 0; k < 4 * CN; k++) add_word(1000, -3);
        build_expect(4);
        run_batch(4, 1'b1);

        // Saturation at both rails over 63 epochs
        for (int k = 0; k < 63 * CN; k++) add_word((1 << (HW - 1)) - 1, -(1 << (HW - 1)));
        build_expect(63);
        run_batch(63, 1'b0);

        // coh_number of zero behaves as one
        for (int k = 0; k < 2 * CN; k++) add_word(rnd_half(), rnd_half());
        build_expect(0);
        run_batch(0, 1'b0);

        // Random periods
        for (int t = 0; t < 5; t++) begin
            cohn = (t == 4) ? 40 : int'($urandom_range(1, 6));
            nper = int'($urandom_range(1, 2));
            for (int k = 0; k < nper * cohn * CN; k++) add_word(rnd_half(), rnd_half());
            build_expect(cohn);
            run_batch(cohn, t[0]);
        end

        // Enable dropped partway through epoch 0, then a fresh period
        for (int k = 0; k < 2 * CN; k++) add_word(rnd_half(), rnd_half());
        wl_i.delete();
        wl_q.delete();
        coh_number = 6'd2;
        @(posedge clk);
        #1 rd_count = 0;
        enable = 1'b1;
        for (n = 0; n < 200; n++) begin
            @(posedge clk);
            #2;
            if (rd_count >= 5) break;
        end
        enable = 1'b0;
        chk("stop_read_count", rd_count, 5);
        wait_idle();
        fifo_q.delete();
        repeat (2) @(posedge clk);
        for (int k = 0; k < 2 * CN; k++) add_word(rnd_half(), rnd_half());
        build_expect(2);
        run_batch(2, 1'b0);

        // Reset in the middle of a running stream
        for (int k = 0; k < 8 * CN; k++) add_word(rnd_half(), rnd_half());
        build_expect(1);
        coh_number = 6'd1;
        @(posedge clk);
        #1 rd_count = 0;
        enable = 1'b1;
        for (n = 0; n < 500; n++) begin
            @(posedge clk);
            #2;
            if (rd_count >= 20) break;
        end
        rst_b = 1'b0;
        enable = 1'b0;
        @(posedge clk);
        #1 rst_b = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        @(negedge clk);
        check_zero_outputs("midrun_reset");
        for (int k = 0; k < 3 * CN; k++) add_word(rnd_half(), rnd_half());
        build_expect(3);
        run_batch(3, 1'b0);

        chk("rd_while_empty", rd_bad, 0);
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
